// File: rtl/fnd_pkg.sv
// Shared types and constants for the 4-digit FND scan controller.
// Holds the load FSM state enum, digit/value widths, the active-low
// segment patterns and small decode helpers used by the top module.
package fnd_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned VALUE_W    = 14;
  localparam int unsigned BCD_W      = 4 * NUM_DIGITS;
  localparam int unsigned SEG_W      = 8;

  localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = 4'b1111;
  localparam logic [SEG_W-1:0]      SEG_BLANK = 8'hFF;

  // Active-low patterns, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0 = 8'hC0;
  localparam logic [SEG_W-1:0] SEG_1 = 8'hF9;
  localparam logic [SEG_W-1:0] SEG_2 = 8'hA4;
  localparam logic [SEG_W-1:0] SEG_3 = 8'hB0;
  localparam logic [SEG_W-1:0] SEG_4 = 8'h99;
  localparam logic [SEG_W-1:0] SEG_5 = 8'h92;
  localparam logic [SEG_W-1:0] SEG_6 = 8'h82;
  localparam logic [SEG_W-1:0] SEG_7 = 8'hF8;
  localparam logic [SEG_W-1:0] SEG_8 = 8'h80;
  localparam logic [SEG_W-1:0] SEG_9 = 8'h90;

  localparam logic [VALUE_W-1:0] MAX_VALUE = 14'd9999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } load_state_e;

  // BCD nibble to active-low segments; non-decimal nibbles are blank
  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] nib);
    logic [SEG_W-1:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Digit index to active-low one-cold select
  function automatic logic [NUM_DIGITS-1:0] digit_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/fnd_bin2bcd.sv
// Sequential double-dabble converter: 14-bit binary to 4-digit BCD.
// start_i loads bin_i; one adjust+shift per cycle for VALUE_W cycles.
// done_o is high during the final shift cycle, so bcd_o is valid from
// the following cycle and stays stable until the next start.
// Ports: clk_i, rst_i (async, active-high), start_i, bin_i, done_o, bcd_o.
module fnd_bin2bcd
  import fnd_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [VALUE_W-1:0] bin_i,
  output logic               done_o,
  output logic [BCD_W-1:0]   bcd_o
);

  localparam int unsigned SH_W  = BCD_W + VALUE_W;
  localparam int unsigned CNT_W = $clog2(VALUE_W);
  localparam int unsigned LAST  = VALUE_W - 1;

  logic [SH_W-1:0]  sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // One double-dabble iteration: add 3 to BCD nibbles >= 5, then shift
  function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] s);
    logic [SH_W-1:0] a;
    a = s;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (a[VALUE_W + 4*n +: 4] >= 4'd5)
        a[VALUE_W + 4*n +: 4] = a[VALUE_W + 4*n +: 4] + 4'd3;
    end
    return {a[SH_W-2:0], 1'b0};
  endfunction

  // Next-state: load on start, iterate while busy
  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (busy_q) begin
      sh_d   = dd_step(sh_q);
      cnt_d  = cnt_q + CNT_W'(1);
      done_d = (cnt_q == CNT_W'(LAST - 1));
      if (cnt_q == CNT_W'(LAST)) busy_d = 1'b0;
    end else if (start_i) begin
      sh_d   = {BCD_W'(0), bin_i};
      cnt_d  = '0;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  assign bcd_o  = sh_q[SH_W-1 -: BCD_W];

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed controller for a 4-digit common-anode 7-segment display.
// Accepts a binary value (valid/ready), clamps it to 9999, converts it to
// BCD, commits it to a display register and scans the digits every
// SCAN_DIV cycles with registered active-low digit/segment outputs.
// Ports: i_clk, i_reset (async, active-high), i_en, i_valid, i_value[13:0],
//        o_ready, o_digit[3:0] (active-low), o_seg[7:0] ({dp,g..a}, active-low).
// Optional: define FND_LZ_BLANK_EN to blank leading zero digits.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic [VALUE_W-1:0]    i_value,
  output logic                  o_ready,
  output logic [NUM_DIGITS-1:0] o_digit,
  output logic [SEG_W-1:0]      o_seg
);

  localparam int unsigned PRESC_W = $clog2(SCAN_DIV);

  load_state_e            state_q, state_d;
  logic                   ready_q, ready_d;
  logic [BCD_W-1:0]       disp_q, disp_d;
  logic [PRESC_W-1:0]     presc_q, presc_d;
  logic [1:0]             idx_q, idx_d;
  logic                   scan_on_q, scan_on_d;
  logic [NUM_DIGITS-1:0]  digit_q, digit_d;
  logic [SEG_W-1:0]       seg_q, seg_d;

  logic [VALUE_W-1:0]     value_clamped_c;
  logic                   accept_c;
  logic                   bcd_done;
  logic [BCD_W-1:0]       bcd;
  logic                   slot_tc_c;
  logic                   lz_blank_c;
  logic [3:0]             nib_c;

  assign value_clamped_c = (i_value > MAX_VALUE) ? MAX_VALUE : i_value;
  assign accept_c        = i_valid && ready_q;

  fnd_bin2bcd u_bin2bcd (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .start_i (accept_c),
    .bin_i   (value_clamped_c),
    .done_o  (bcd_done),
    .bcd_o   (bcd)
  );

  // Load FSM: accept, convert, then commit to the display register
  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = CONV;
      CONV:    if (bcd_done) state_d = COMMIT;
      COMMIT: begin
        disp_d  = bcd;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // Scan: prescaler/index advance and slot-aligned output register update.
  // Outputs reload only at a slot boundary (or the first enabled cycle),
  // sampling the display register as it was before this edge.
  always_comb begin
    presc_d    = presc_q;
    idx_d      = idx_q;
    scan_on_d  = i_en;
    digit_d    = digit_q;
    seg_d      = seg_q;
    slot_tc_c  = (presc_q == PRESC_W'(SCAN_DIV - 1));
    nib_c      = 4'h0;
    lz_blank_c = 1'b0;
    if (!i_en) begin
      presc_d = '0;
      idx_d   = '0;
      digit_d = DIGIT_OFF;
      seg_d   = SEG_BLANK;
    end else begin
      if (slot_tc_c) begin
        presc_d = '0;
        idx_d   = idx_q + 2'd1;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
      if (!scan_on_q || slot_tc_c) begin
        nib_c = 4'(disp_q >> {idx_d, 2'b00});
`ifdef FND_LZ_BLANK_EN
        // Blank when this digit and every more significant one are zero
        lz_blank_c = (idx_d != 2'd0) && ((disp_q >> {idx_d, 2'b00}) == '0);
`endif
        if (lz_blank_c) begin
          digit_d = DIGIT_OFF;
          seg_d   = SEG_BLANK;
        end else begin
          digit_d = digit_sel(idx_d);
          seg_d   = seg_decode(nib_c);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      disp_q    <= '0;
      presc_q   <= '0;
      idx_q     <= '0;
      scan_on_q <= 1'b0;
      digit_q   <= DIGIT_OFF;
      seg_q     <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      disp_q    <= disp_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      scan_on_q <= scan_on_d;
      digit_q   <= digit_d;
      seg_q     <= seg_d;
    end
  end

  assign o_ready = ready_q;
  assign o_digit = digit_q;
  assign o_seg   = seg_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller with SCAN_DIV = 4.
// A cycle-level reference model tracks the displayed value, the load
// latency and the scan position arithmetically; directed scenarios and
// randomized traffic are checked against it every cycle.
module tb_fnd_scan_controller;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        valid;
  logic [13:0] value;
  logic        ready;
  logic [3:0]  digit;
  logic [7:0]  seg;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int         m_disp;
  int         m_pend;
  int         m_busy;
  int         m_k;
  logic [3:0] m_dig;
  logic [7:0] m_seg;
  logic [7:0] seg_tab [10];
  int         p10 [4];

  always #5 clk = ~clk;

  fnd_scan_controller #(.SCAN_DIV(SD)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_en    (en),
    .i_valid (valid),
    .i_value (value),
    .o_ready (ready),
    .o_digit (digit),
    .o_seg   (seg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_disp = 0;
    m_pend = 0;
    m_busy = 0;
    m_k    = 0;
    m_dig  = 4'hF;
    m_seg  = 8'hFF;
  endtask

  // Effect of one rising edge, given the inputs applied before it
  task automatic model_edge();
    int   idx;
    logic blank;
    if (rst) return;
    if (en) begin
      // Slot k/SD of the enabled run; output reloads at each slot start
      if (m_k == 0 || ((m_k + 1) % SD) == 0) begin
        idx   = ((m_k + 1) / SD) % 4;
        blank = 1'b0;
`ifdef FND_LZ_BLANK_EN
        blank = (idx > 0) && (m_disp < p10[idx]);
`endif
        if (blank) begin
          m_dig = 4'hF;
          m_seg = 8'hFF;
        end else begin
          m_dig      = 4'hF;
          m_dig[idx] = 1'b0;
          m_seg      = seg_tab[(m_disp / p10[idx]) % 10];
        end
      end
      m_k++;
    end else begin
      m_k   = 0;
      m_dig = 4'hF;
      m_seg = 8'hFF;
    end
    // Load path: ready low 15 cycles, display updated on the 15th edge
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) m_disp = m_pend;
    end else if (valid) begin
      m_pend = (int'(value) > 9999) ? 9999 : int'(value);
      m_busy = 15;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("digit", digit, m_dig);
    check("seg", seg, m_seg);
    check("ready", ready, (m_busy == 0));
  endtask

  // Offer a value for one cycle and measure how long ready stays low
  task automatic load_timed(input string tag, input int v);
    int n;
    value = 14'(v);
    valid = 1'b1;
    step();
    valid = 1'b0;
    n = 0;
    while (ready === 1'b0 && n < 100) begin
      n++;
      step();
    end
    check({tag, "_ready_low"}, n, 15);
  endtask

  // Watch two scan rounds and compare lit digits with fixed patterns
  task automatic check_scan(input string tag, input logic [3:0] mask,
                            input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    logic [3:0] seen;
    seen = 4'h0;
    for (int i = 0; i < 8 * SD; i++) begin
      step();
      case (digit)
        4'b1110: begin seen[0] = 1'b1; check({tag, "_d0"}, seg, s0); end
        4'b1101: begin seen[1] = 1'b1; check({tag, "_d1"}, seg, s1); end
        4'b1011: begin seen[2] = 1'b1; check({tag, "_d2"}, seg, s2); end
        4'b0111: begin seen[3] = 1'b1; check({tag, "_d3"}, seg, s3); end
        default: ;
      endcase
    end
    check({tag, "_lit"}, seen, mask);
  endtask

  initial begin
    int r;
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    p10     = '{1, 10, 100, 1000};
    rst   = 1'b1;
    en    = 1'b0;
    valid = 1'b0;
    value = '0;
    model_reset();

    // Reset state
    @(posedge clk);
    #1;
    check("rst_digit", digit, 4'hF);
    check("rst_seg", seg, 8'hFF);
    check("rst_ready", ready, 1'b1);
    rst = 1'b0;
    en  = 1'b1;

    // Idle scan of zero
`ifdef FND_LZ_BLANK_EN
    check_scan("zero", 4'b0001, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
`else
    check_scan("zero", 4'b1111, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
`endif

    // Plain load
    load_timed("l1234", 1234);
    repeat (2 * SD) step();
    check_scan("v1234", 4'b1111, 8'h99, 8'hB0, 8'hA4, 8'hF9);

    // Clamp above 9999
    load_timed("l12000", 12000);
    repeat (2 * SD) step();
    check_scan("clamp", 4'b1111, 8'h90, 8'h90, 8'h90, 8'h90);

    // Second offer during conversion is dropped
    value = 14'd1234;
    valid = 1'b1;
    step();
    value = 14'd5678;
    repeat (6) step();
    valid = 1'b0;
    repeat (20) step();
    check_scan("ovl", 4'b1111, 8'h99, 8'hB0, 8'hA4, 8'hF9);

    // Enable drop mid-scan, restart at digit 0
    repeat (SD + 1) step();
    en = 1'b0;
    repeat (10) step();
    check("dis_digit", digit, 4'hF);
    check("dis_seg", seg, 8'hFF);
    en = 1'b1;
    step();
    check("reen_digit0", digit, 4'b1110);
    check("reen_seg0", seg, 8'h99);

    // Single-digit value
    load_timed("l7", 7);
    repeat (2 * SD) step();
`ifdef FND_LZ_BLANK_EN
    check_scan("v7", 4'b0001, 8'hF8, 8'hFF, 8'hFF, 8'hFF);
`else
    check_scan("v7", 4'b1111, 8'hF8, 8'hC0, 8'hC0, 8'hC0);
`endif

    // Reset in the middle of a conversion
    value = 14'd4321;
    valid = 1'b1;
    step();
    valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    #1;
    check("arst_digit", digit, 4'hF);
    check("arst_seg", seg, 8'hFF);
    check("arst_ready", ready, 1'b1);
    model_reset();
    step();
    rst = 1'b0;
    repeat (30) step();

    // Randomized traffic, biased toward the clamp boundary
    repeat (3000) begin
      r     = int'($urandom_range(0, 3));
      value = (r == 0) ? 14'(9998 + $urandom_range(0, 3)) : 14'($urandom_range(0, 16383));
      valid = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) en = ~en;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Time-multiplexed controller for a 4-digit, common-anode 7-segment (FND) display. It accepts a binary value over a valid/ready handshake and converts it to BCD with a sequential double-dabble engine. It then scans the four digits at a programmable refresh rate, driving active-low digit selects and segment patterns. It sits between the AXI4-Lite register slave of the FND IP and the board pins.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz). Legal range is 2 or more.
- `i_clk  in  1`: system clock. All logic is on the rising edge.
- `i_reset  in  1`: asynchronous, active-high reset.
- `i_en  in  1`: display on/off. When 0, all digits are dark.
- `i_valid  in  1`: new value offered.
- `i_value  in  14`: unsigned binary value to display.
- `o_ready  out  1`: controller can accept a value.
- `o_digit  out  4`: active-low digit select. Bit n low means digit n is lit. Digit 0 is the least significant.
- `o_seg  out  8`: active-low segments, ordered {dp,g,f,e,d,c,b,a}. The dp bit is always 1.

## Operation
- Load FSM has three states.
  - IDLE: `o_ready` = 1. When `i_valid` && `o_ready`, latch the clamped value and go to CONV.
  - CONV: 14 cycles, one double-dabble shift per cycle (add 3 to each nibble ≥5, then shift). `o_ready` = 0.
  - COMMIT: 1 cycle. Copy the 16-bit BCD result to the display register, then go to IDLE.
- Clamp rule: if `i_value` > 9999, 9999 is used.
- `i_valid` is ignored while `o_ready` = 0. No queueing.
- The display register changes only in COMMIT. Partial BCD is never shown.
- Scan logic:
  - The prescaler counts 0..SCAN_DIV-1.
  - At the terminal count, the digit index increments. It wraps 3 to 0.
- Segment decode (active-low):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Nibbles A–F give FF (blank). These cannot occur in normal operation.
- Digit select for index 0..3 is 1110, 1101, 1011, 0111.
- While `i_en` = 0:
  - `o_digit` = 1111 and `o_seg` = FF.
  - Prescaler and index are held at 0.
  - The load FSM keeps operating.

## Timing
- Reset values: `o_digit` = 1111, `o_seg` = FF, `o_ready` = 1, FSM = IDLE, display register = 0000, prescaler = 0, index = 0.
- `o_digit` and `o_seg` are registered. Both are updated from the current index and display register one cycle after the index changes. They always switch in the same cycle, so there is no ghosting between digits.
- Load latency, for a handshake accepted on cycle T:
  - Conversion runs on cycles T+1..T+14.
  - COMMIT happens on T+15.
  - `o_ready` returns to 1 on T+16.
  - The new digits appear on outputs starting at the next scan slot's registered update.
- Enable edge: on `i_en` 0→1 at cycle T, digit 0 is driven from cycle T+1.
- A slot change on the same cycle as COMMIT: the output register samples the old display register. The new value shows from the following slot.
- Reset asserted mid-conversion aborts the conversion. The display register returns to 0000.

## Configuration
- `FND_LZ_BLANK_EN`
  - Defined: leading zeros are blanked. For a digit above the most significant nonzero digit, `o_digit` = 1111 during its slot and `o_seg` = FF. Digit 0 is never blanked, so value 0 shows "0". Example: 42 shows as "  42".
  - Undefined: all four digits are always lit. Example: 42 shows as "0042".

## Structure
- Package `fnd_pkg` holds:
  - The FSM state enum (IDLE, CONV, COMMIT).
  - `NUM_DIGITS` = 4 and `VALUE_W` = 14.
  - `DIGIT_OFF` = 4'b1111 and `SEG_BLANK` = 8'hFF.
  - The SEG_0..SEG_9 constants.
  - The `MAX_VALUE` = 9999 constant.
- One sub-module, `fnd_bin2bcd`: the sequential double-dabble engine with start/done, 14-bit in, 16-bit out. The scan and decode logic stays in the top module.

## Test plan
(SCAN_DIV = 4 in simulation)
- Reset:
  - Assert `i_reset` mid-run → `o_digit` = 1111, `o_seg` = FF, `o_ready` = 1 in the same cycle, without waiting for a clock edge.
  - Release reset, `i_en` = 1, no load → digits cycle 1110, 1101, 1011, 0111 every 4 cycles. `o_seg` = C0 on every digit (first digit with `FND_LZ_BLANK_EN`).
- Load 1234 → `o_ready` is low for exactly 15 cycles. Afterwards the segments are digit0 = 99, digit1 = B0, digit2 = A4, digit3 = F9.
- Load 12000 → display shows 9999, with `o_seg` = 90 on all four digits.
- Assert `i_valid` with 5678 during the CONV of 1234 → the second value is ignored. The display settles at 1234.
- Drop `i_en` for 10 cycles mid-scan → outputs are 1111/FF while low. After re-enable, the scan restarts at digit 0 on the next cycle.
- With `FND_LZ_BLANK_EN` defined, load 7 → only digit 0 is lit (`o_seg` = F8). The other slots show `o_digit` = 1111.
